// File: rtl/tanh_sched_pkg.sv
// tanh_sched_pkg
// Shared constants and types for the tanh lane scheduler.
//   DATA_W / FRAC_W : Q5.11 operand format
//   UNIT_LAT        : fixed pipeline depth of the shared tanh unit
//   lane_tag_t      : owner record for one issue slot (both lanes)
//   SAT_HI / SAT_LO : saturated tanh outputs produced by the unit
package tanh_sched_pkg;

  localparam int DATA_W   = 16;
  localparam int FRAC_W   = 11;
  localparam int UNIT_LAT = 3;

  // Wide enough for the largest supported requester count (8).
  localparam int ID_W = 3;

  localparam logic signed [DATA_W-1:0] SAT_HI = 16'sd2038;
  localparam logic signed [DATA_W-1:0] SAT_LO = -16'sd2038;

  typedef struct packed {
    logic            v0;
    logic [ID_W-1:0] id0;
    logic            v1;
    logic [ID_W-1:0] id1;
  } lane_tag_t;

  function automatic logic tag_any(input lane_tag_t t);
    return t.v0 | t.v1;
  endfunction

endpackage

// File: rtl/tanh_resp_fifo.sv
// tanh_resp_fifo
// Per-requester result FIFO. Upstream credits guarantee a write never
// meets a full FIFO; the full guard only protects the pointers.
//   clk, rst_n : clock, async active-low reset (empties the FIFO)
//   wr_en      : push wr_data
//   rd_en      : pop the head (ignored when empty)
//   rd_data    : head entry, forced to 0 while empty
//   empty      : no entries stored
module tanh_resp_fifo
  import tanh_sched_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = DATA_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         full;
  logic         do_wr;
  logic         do_rd;

  // Extra pointer MSB distinguishes full from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/tanh_lane_scheduler.sv
// tanh_lane_scheduler
// Shares one 2-lane tanh unit between NREQ requesters. Up to two operands
// are granted per cycle (round-robin), issued to the unit lanes, tracked by
// an owner tag through the unit latency and retired into per-requester
// response FIFOs.
//   clk, rst_n          : clock, async active-low reset
//   req_valid/ready/x   : per-requester operand stream (16 bits each)
//   resp_valid/ready/y  : per-requester result stream (FIFO head)
//   u_x0, u_x1, u_valid : registered unit lane inputs
//   u_y0, u_y1, u_valid_out : unit lane outputs
//   err                 : sticky unit/tag disagreement
module tanh_lane_scheduler
  import tanh_sched_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int RESP_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [DATA_W*NREQ-1:0]   req_x,
  output logic [NREQ-1:0]          resp_valid,
  input  logic [NREQ-1:0]          resp_ready,
  output logic [DATA_W*NREQ-1:0]   resp_y,
  output logic [DATA_W-1:0]        u_x0,
  output logic [DATA_W-1:0]        u_x1,
  output logic                     u_valid,
  input  logic [DATA_W-1:0]        u_y0,
  input  logic [DATA_W-1:0]        u_y1,
  input  logic                     u_valid_out,
  output logic                     err
);

  localparam int CRED_W = $clog2(RESP_DEPTH + 1);
  localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CRED_W-1:0] CRED_ONE  = CRED_W'(1);
  localparam logic [CRED_W-1:0] CRED_FULL = CRED_W'(RESP_DEPTH);
  localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NREQ - 1);

  // Holds grants off for the first cycle out of reset so req_ready reads 0
  // while rst_n is low even if requesters already assert req_valid.
  logic active;

  logic [NREQ-1:0]  eligible;
  logic [NREQ-1:0]  grant;
  logic [IDX_W-1:0] rr;
  logic [IDX_W-1:0] rr_next;
  logic             g0_hit;
  logic             g1_hit;
  logic [IDX_W-1:0] g0_id;
  logic [IDX_W-1:0] g1_id;
  logic [IDX_W-1:0] last_id;

  lane_tag_t issue_tag;
  lane_tag_t tag_pipe [UNIT_LAT];
  lane_tag_t tail_tag;
  logic      tail_any;
  logic      armed;

  logic [NREQ-1:0]   fifo_wr;
  logic [DATA_W-1:0] fifo_wdata [NREQ];
  logic [NREQ-1:0]   fifo_empty;
  logic [NREQ-1:0]   pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) active <= 1'b0;
    else        active <= 1'b1;
  end

  // Round-robin: lane 0 takes the first eligible requester at or after rr,
  // lane 1 the next distinct eligible one.
  always_comb begin
    g0_hit  = 1'b0;
    g1_hit  = 1'b0;
    g0_id   = '0;
    g1_id   = '0;
    grant   = '0;
    last_id = '0;
    rr_next = rr;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = int'(rr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (eligible[idx]) begin
        if (!g0_hit) begin
          g0_hit = 1'b1;
          g0_id  = IDX_W'(idx);
        end else if (!g1_hit) begin
          g1_hit = 1'b1;
          g1_id  = IDX_W'(idx);
        end
      end
    end
    if (g0_hit) grant[g0_id] = 1'b1;
    if (g1_hit) grant[g1_id] = 1'b1;
    last_id = g1_hit ? g1_id : g0_id;
    if (g0_hit) rr_next = (last_id == IDX_LAST) ? '0 : last_id + IDX_ONE;
  end

  assign req_ready = grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr <= '0;
    else        rr <= rr_next;
  end

  // Issue: the issue_tag register travels alongside u_x/u_valid, so after
  // UNIT_LAT further stages the tail lines up with the unit's output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_x0      <= '0;
      u_x1      <= '0;
      u_valid   <= 1'b0;
      issue_tag <= '0;
    end else begin
      u_x0          <= g0_hit ? req_x[int'(g0_id)*DATA_W +: DATA_W] : '0;
      u_x1          <= g1_hit ? req_x[int'(g1_id)*DATA_W +: DATA_W] : '0;
      u_valid       <= g0_hit;
      issue_tag.v0  <= g0_hit;
      issue_tag.id0 <= ID_W'(g0_id);
      issue_tag.v1  <= g1_hit;
      issue_tag.id1 <= ID_W'(g1_id);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < UNIT_LAT; s++) tag_pipe[s] <= '0;
    end else begin
      tag_pipe[0] <= issue_tag;
      for (int s = 1; s < UNIT_LAT; s++) tag_pipe[s] <= tag_pipe[s-1];
    end
  end

  assign tail_tag = tag_pipe[UNIT_LAT-1];
  assign tail_any = tag_any(tail_tag);

  // After reset the unit may still flush results issued before reset; they
  // are ignored until the first valid tag reaches the tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b0;
      err   <= 1'b0;
    end else begin
      if (tail_any) armed <= 1'b1;
      if ((armed || tail_any) && (u_valid_out != tail_any)) err <= 1'b1;
    end
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_req
    logic              hit0;
    logic              hit1;
    logic [CRED_W-1:0] credit;

    assign hit0          = tail_tag.v0 && (tail_tag.id0 == ID_W'(i));
    assign hit1          = tail_tag.v1 && (tail_tag.id1 == ID_W'(i));
    assign fifo_wr[i]    = hit0 | hit1;
    assign fifo_wdata[i] = hit0 ? u_y0 : u_y1;
    assign pop[i]        = resp_valid[i] & resp_ready[i];
    assign resp_valid[i] = ~fifo_empty[i];
    assign eligible[i]   = active & req_valid[i] & (credit != '0);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        credit <= CRED_FULL;
      end else begin
        case ({grant[i], pop[i]})
          2'b10:   credit <= credit - CRED_ONE;
          2'b01:   credit <= credit + CRED_ONE;
          default: credit <= credit;
        endcase
      end
    end

    tanh_resp_fifo #(
      .DEPTH (RESP_DEPTH),
      .W     (DATA_W)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (fifo_wr[i]),
      .wr_data (fifo_wdata[i]),
      .rd_en   (pop[i]),
      .rd_data (resp_y[i*DATA_W +: DATA_W]),
      .empty   (fifo_empty[i])
    );
  end

endmodule

// File: tb/tb_tanh_lane_scheduler.sv
// Bench for tanh_lane_scheduler: behavioural tanh unit, scoreboard keyed by
// requester, directed scenarios followed by random traffic.
module tb_tanh_lane_scheduler;
  import tanh_sched_pkg::*;

  localparam int NREQ  = 4;
  localparam int DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [16*NREQ-1:0]     req_x;
  logic [NREQ-1:0]        resp_valid;
  logic [NREQ-1:0]        resp_ready;
  logic [16*NREQ-1:0]     resp_y;
  logic [15:0]            u_x0, u_x1, u_y0, u_y1;
  logic                   u_valid, u_valid_out, err;
  logic                   inj;

  always #5 clk = ~clk;

  tanh_lane_scheduler #(.NREQ(NREQ), .RESP_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_y(resp_y),
    .u_x0(u_x0), .u_x1(u_x1), .u_valid(u_valid),
    .u_y0(u_y0), .u_y1(u_y1), .u_valid_out(u_valid_out),
    .err(err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Real tanh in Q5.11, rounded, clamped to the unit's saturation level.
  function automatic int tanh_ref(input logic [15:0] x);
    real a, e, t;
    int  m;
    a = $itor($signed(x)) / 2048.0;
    if (a < 0.0) a = -a;
    e = $exp(2.0 * a);
    t = (e - 1.0) / (e + 1.0);
    m = $rtoi(t * 2048.0 + 0.5);
    if (m > 2038) m = 2038;
    if ($signed(x) < 0) m = -m;
    return m;
  endfunction

  // Behavioural shared unit: 3-cycle pipeline, not reset by rst_n.
  logic        mv  [3] = '{1'b0, 1'b0, 1'b0};
  logic [15:0] my0 [3] = '{16'h0, 16'h0, 16'h0};
  logic [15:0] my1 [3] = '{16'h0, 16'h0, 16'h0};
  always @(posedge clk) begin
    logic sv;
    logic [15:0] sa, sb;
    sv = u_valid; sa = u_x0; sb = u_x1;
    #1;
    mv[2] = mv[1];   mv[1] = mv[0];   mv[0] = sv;
    my0[2] = my0[1]; my0[1] = my0[0]; my0[0] = 16'(tanh_ref(sa));
    my1[2] = my1[1]; my1[1] = my1[0]; my1[0] = 16'(tanh_ref(sb));
  end
  assign u_valid_out = mv[2] | inj;
  assign u_y0 = my0[2];
  assign u_y1 = my1[2];

  // Scoreboard
  int              exp_q [NREQ][$];
  int              got   [NREQ][$];
  int              acc_cnt [NREQ] = '{0, 0, 0, 0};
  logic [NREQ-1:0] acc_vec;
  int              phase = 0;
  logic            x1_nonzero = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) exp_q[i].delete();
    end else begin
      acc_vec = req_valid & req_ready;
      for (int i = 0; i < NREQ; i++) begin
        if (acc_vec[i]) begin
          exp_q[i].push_back(tanh_ref(req_x[16*i +: 16]));
          acc_cnt[i]++;
        end
        if (resp_valid[i] && resp_ready[i]) begin
          chk($sformatf("resp_expected_r%0d", i), (exp_q[i].size() > 0) ? 1 : 0, 1);
          if (exp_q[i].size() > 0)
            chk($sformatf("resp_data_r%0d", i), $signed(resp_y[16*i +: 16]), exp_q[i].pop_front());
          got[i].push_back(int'($signed(resp_y[16*i +: 16])));
        end
      end
      if (phase == 1 && u_x1 != 16'h0) x1_nonzero = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_resp_y"}, resp_y, 0);
    chk({tag, "_u_x0"}, u_x0, 0);
    chk({tag, "_u_x1"}, u_x1, 0);
    chk({tag, "_u_valid"}, u_valid, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
  endtask

  task automatic drive_cycles(input int n);
    logic [NREQ-1:0] acc;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      step();
      for (int i = 0; i < NREQ; i++)
        if (acc[i]) req_x[16*i +: 16] = 16'($urandom);
    end
  endtask

  task automatic wait_drain(input string tag);
    int tot;
    tot = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      tot = 0;
      for (int i = 0; i < NREQ; i++) tot += exp_q[i].size();
      if (tot == 0) break;
    end
    chk({tag, "_drained"}, tot, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  t_acc, b0, b1, b2;
    bit  found;
    logic [NREQ-1:0] acc;

    rst_n = 1'b0; req_valid = '0; req_x = '0; resp_ready = '0; inj = 1'b0;
    repeat (2) @(posedge clk);
    #2 chk_rst("rst0");
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) step();

    // Single requester, directed operands
    resp_ready = '1;
    phase = 1;
    got[0].delete();
    req_valid[0] = 1'b1; req_x[15:0] = 16'h0400;
    @(negedge clk);
    t_acc = cyc;
    chk("t1_accept", req_ready[0], 1);
    step(); req_x[15:0] = 16'h0800;
    @(negedge clk);
    chk("t1_u_valid", u_valid, 1);
    chk("t1_u_x0", u_x0, 16'h0400);
    step(); req_x[15:0] = 16'h0000;
    step(); req_valid[0] = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (resp_valid[0]) found = 1'b1;
    end
    chk("t1_resp_seen", found, 1);
    if (found) chk("t1_latency", cyc - t_acc, 5);
    for (int k = 0; k < 20 && got[0].size() < 3; k++) @(negedge clk);
    chk("t1_count", got[0].size(), 3);
    if (got[0].size() >= 3) begin
      chk("t1_y0", got[0][0], 946);
      chk("t1_y1", got[0][1], 1560);
      chk("t1_y2", got[0][2], 0);
    end
    chk("t1_u_x1_zero", x1_nonzero, 0);
    phase = 0;

    // Four requesters continuously valid
    do_reset();
    resp_ready = '1;
    b0 = acc_cnt[0]; b1 = acc_cnt[1]; b2 = acc_cnt[2];
    t_acc = acc_cnt[3];
    req_valid = '1;
    for (int i = 0; i < NREQ; i++) req_x[16*i +: 16] = 16'($urandom);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("t2_grant_c%0d", k), req_ready, (k % 2 == 0) ? 4'b0011 : 4'b1100);
      acc = req_valid & req_ready;
      step();
      for (int i = 0; i < NREQ; i++)
        if (acc[i]) req_x[16*i +: 16] = 16'($urandom);
    end
    req_valid = '0;
    chk("t2_acc_r0", acc_cnt[0] - b0, 4);
    chk("t2_acc_r1", acc_cnt[1] - b1, 4);
    chk("t2_acc_r2", acc_cnt[2] - b2, 4);
    chk("t2_acc_r3", acc_cnt[3] - t_acc, 4);
    wait_drain("t2");

    // Saturation on both lanes in one cycle
    got[2].delete(); got[3].delete();
    step();
    req_valid = 4'b1100;
    req_x[47:32] = 16'h2000;
    req_x[63:48] = 16'hE000;
    @(negedge clk);
    chk("t3_grant", req_ready, 4'b1100);
    step(); req_valid = '0;
    for (int k = 0; k < 20 && (got[2].size() == 0 || got[3].size() == 0); k++) @(negedge clk);
    chk("t3_count", got[2].size() + got[3].size(), 2);
    if (got[2].size() > 0) chk("t3_sat_hi", got[2][0], int'(SAT_HI));
    if (got[3].size() > 0) chk("t3_sat_lo", got[3][0], int'(SAT_LO));

    // Backpressure on requester 1
    do_reset();
    resp_ready = 4'b1101;
    b0 = acc_cnt[0]; b1 = acc_cnt[1]; b2 = acc_cnt[2];
    req_valid = 4'b0111;
    for (int i = 0; i < NREQ; i++) req_x[16*i +: 16] = 16'($urandom);
    drive_cycles(16);
    chk("t4_r1_accepts", acc_cnt[1] - b1, 4);
    chk("t4_others_flow", (acc_cnt[0] - b0 > 4 && acc_cnt[2] - b2 > 4) ? 1 : 0, 1);
    @(negedge clk);
    chk("t4_r1_blocked", req_ready[1], 0);
    chk("t4_r1_resp_valid", resp_valid[1], 1);
    b1 = acc_cnt[1];
    step(); resp_ready[1] = 1'b1;
    step(); resp_ready[1] = 1'b0;
    drive_cycles(10);
    chk("t4_single_regrant", acc_cnt[1] - b1, 1);
    req_valid = '0;
    resp_ready = '1;
    wait_drain("t4");

    // Reset with operations in flight
    step();
    req_valid = 4'b0001; req_x[15:0] = 16'($urandom);
    drive_cycles(3);
    rst_n = 1'b0;
    #2 chk_rst("t5_rst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    req_valid = '0;
    resp_ready = '0;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (resp_valid != '0 || err) found = 1'b1;
    end
    chk("t5_no_stale", found, 0);
    b0 = acc_cnt[0];
    step();
    req_valid = 4'b0001;
    drive_cycles(12);
    chk("t5_credits", acc_cnt[0] - b0, DEPTH);
    req_valid = '0;
    resp_ready = '1;
    wait_drain("t5");

    // Spurious unit valid
    repeat (6) step();
    inj = 1'b1;
    @(negedge clk);
    chk("t6_err_before", err, 0);
    step(); inj = 1'b0;
    @(negedge clk);
    chk("t6_err_set", err, 1);
    repeat (5) step();
    chk("t6_err_sticky", err, 1);
    do_reset();
    chk("t6_err_cleared", err, 0);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || acc[i]) begin
          req_valid[i] = ($urandom_range(3) != 0);
          req_x[16*i +: 16] = 16'($urandom);
        end
      end
      resp_ready = NREQ'($urandom);
    end
    req_valid = '0;
    resp_ready = '1;
    wait_drain("rand");
    chk("rand_err", err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
